seg7_scan_ctrl: RTL
===================

// Module: seg7_scan_ctrl
// PURPOSE
//  Scan controller for the board's 4-digit 7-segment display, driven from the CPU store path.
//  CPU writes per-digit data (hex-decoded or raw pattern) into shadow registers.
//  Shadow registers commit to display registers once per frame, so the display never tears.
//  Time-multiplexes the digits with a blanking gap between digits to suppress ghosting.
//  Its sel/seg outputs feed the top-level display mux (the gpio override stays above it).
// PARAMETERS
//  SCAN_DIV      50000  clk cycles each digit is lit (>=2)
//  BLANK_CYCLES  16     clk cycles all digits are dark between digits (>=1)
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  wr_en      in   1   write strobe; one write per cycle
//  wr_addr    in   2   digit index 0..3 (0 = rightmost, sel[0])
//  wr_raw     in   1   1: wr_data is a raw segment pattern; 0: hex-decode wr_data[3:0]
//  wr_data    in   8   raw: {dp,g,f,e,d,c,b,a} active-high; hex: [7]=dp, [3:0]=nibble
//  sel        out  4   digit enable, active-low one-hot, registered
//  seg        out  8   {dp,g..a}, active-low, registered
//  frame_pulse out 1   1-cycle high on each shadow->display commit
// BEHAVIOUR
//  Reset (async assert, sync release): sel=4'hF, seg=8'hFF, frame_pulse=0.
//   All shadow and display registers = 8'hFF (blank). State=BLANK, blank_cnt=0, digit=3.
//  Storage: 4 shadow regs and 4 display regs, each 8 bit and already active-low encoded.
//   hex write: shadow[wr_addr] = {~wr_data[7], ~dec(wr_data[3:0])}.
//   raw write: shadow[wr_addr] = ~wr_data.
//  dec (gfedcba, active-high): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
//  FSM with two states: SHOW and BLANK. Counters are div (0..SCAN_DIV-1) and blank_cnt (0..BLANK_CYCLES-1).
//   SHOW: sel = ~(1<<digit), seg = display[digit]. div increments each cycle.
//    When div==SCAN_DIV-1: div<=0 and go to BLANK.
//   BLANK: sel=4'hF, seg=8'hFF. blank_cnt increments each cycle.
//    When blank_cnt==BLANK_CYCLES-1: blank_cnt<=0, digit<=digit+1 (3 wraps to 0), go to SHOW.
//  Commit: on the BLANK->SHOW edge where digit wraps 3->0, copy all four shadow regs into the display regs.
//   On that same edge frame_pulse=1; it is 0 on every other cycle.
//  Output timing: sel/seg are registered and take their new values on the same edge as the state change.
//   After reset release: BLANK_CYCLES dark cycles, then digit 0 is shown with the committed values.
//  Frame length = 4*(SCAN_DIV+BLANK_CYCLES) cycles. Write-to-visible latency is at most one frame.
//  Write on the commit cycle: commit uses the pre-edge shadow value; the new write lands in shadow
//   and becomes visible at the next commit.
//  Writes to the same digit in consecutive cycles: the last write before the commit wins.
//  Reset asserted mid-frame: immediate blank and full reinit; pending shadow data is discarded.
// TESTING (SCAN_DIV=4, BLANK_CYCLES=2; frame = 24 cycles)
//  Reset release, no writes -> 2 cycles sel=F/seg=FF, then sel=E,D,B,7 each 4 cycles;
//   seg=FF throughout; frame_pulse every 24 cycles.
//  Hex writes 0:0x01, 1:0x02, 2:0x8A, 3:0x0F before commit -> display shows
//   d0 seg=F9, d1 seg=A4, d2 seg=08 (dp on), d3 seg=8E.
//  Raw write addr1 data=0x80 mid-frame -> d1 unchanged until next frame_pulse, then seg=7F.
//  Write addr0 on the exact frame_pulse edge -> old d0 shown for this frame, new value next frame.
//  Assert reset during SHOW of digit 2 -> sel=F, seg=FF at once; after release, dark 2 cycles,
//   then d0 shown blank; earlier data gone.
//  Check: sel is never two-hot and never lit while blank_cnt is active; 1000-frame soak with random writes
//   against a reference model.

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// CPU store-path write port into the 7-segment scan controller's shadow registers.
// The master side drives digit writes and the slave side (the controller) consumes them.
interface seg7_scan_ctrl_if;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic       wr_raw;
  logic [7:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_raw, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_raw, input  wr_data);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// 4-digit 7-segment scan controller: shadow/display double buffering with a once-per-frame
// commit, and time-multiplexed digits separated by all-dark blanking gaps.
module seg7_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  seg7_scan_ctrl_if.slave       wr,
  output logic [3:0]            sel,
  output logic [7:0]            seg,
  output logic                  frame_pulse
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int BLK_W = $clog2(BLANK_CYCLES + 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BLK_W-1:0]   blank_q, blank_d;
  logic [1:0]         digit_q, digit_d;
  logic               commit_s;
  logic [7:0]         wr_value_s;
  logic [7:0]         shadow_q  [4];
  logic [7:0]         display_q [4];
  logic [3:0]         sel_q, sel_d;
  logic [7:0]         seg_q, seg_d;
  logic               frame_pulse_q;

  function automatic logic [6:0] hex_dec(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      4'hF:    pat = 7'h71;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  // Next-state logic for the SHOW/BLANK scan sequencer and its counters
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    blank_d  = blank_q;
    digit_d  = digit_q;
    commit_s = 1'b0;
    case (state_q)
      ST_SHOW: begin
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
          div_d   = '0;
          state_d = ST_BLANK;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_BLANK: begin
        if (blank_q == BLK_W'(BLANK_CYCLES - 1)) begin
          blank_d  = '0;
          digit_d  = digit_q + 2'd1;
          state_d  = ST_SHOW;
          commit_s = (digit_q == 2'd3);
        end else begin
          blank_d = blank_q + BLK_W'(1);
        end
      end
      default: begin
        state_d = ST_BLANK;
      end
    endcase
  end

  // Output decode from the next state so sel/seg change on the same edge as the state.
  // On the commit edge the display registers are still old, so digit 0 reads the shadow.
  always_comb begin
    wr_value_s = wr.wr_raw ? ~wr.wr_data : {~wr.wr_data[7], ~hex_dec(wr.wr_data[3:0])};
    if (state_d == ST_SHOW) begin
      sel_d = ~(4'b0001 << digit_d);
      seg_d = commit_s ? shadow_q[digit_d] : display_q[digit_d];
    end else begin
      sel_d = 4'hF;
      seg_d = 8'hFF;
    end
  end

  // Sequencer state, counters and registered display outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_BLANK;
      div_q         <= '0;
      blank_q       <= '0;
      digit_q       <= 2'd3;
      sel_q         <= 4'hF;
      seg_q         <= 8'hFF;
      frame_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      blank_q       <= blank_d;
      digit_q       <= digit_d;
      sel_q         <= sel_d;
      seg_q         <= seg_d;
      frame_pulse_q <= commit_s;
    end
  end

  // Shadow writes from the CPU and the frame-boundary copy into the display registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        shadow_q[i]  <= 8'hFF;
        display_q[i] <= 8'hFF;
      end
    end else begin
      if (commit_s) begin
        for (int i = 0; i < 4; i++) begin
          display_q[i] <= shadow_q[i];
        end
      end
      if (wr.wr_en) begin
        shadow_q[wr.wr_addr] <= wr_value_s;
      end
    end
  end

  assign sel         = sel_q;
  assign seg         = seg_q;
  assign frame_pulse = frame_pulse_q;

endmodule
